// File: rtl/im_port_arbiter_if.sv
// Shared-port bundle between the fetch unit, the boot/debug loader and the instruction memory.
// The arbiter takes the slave view; requesters and the memory model take the master view.
`timescale 1ns/1ps
interface im_port_arbiter_if #(
  parameter int unsigned ADSize = 16,
  parameter int unsigned DASize = 32
);
  logic              fetch_req;
  logic [ADSize-1:0] fetch_addr;
  logic              fetch_gnt;
  logic              fetch_rvalid;
  logic [DASize-1:0] fetch_rdata;

  logic              ld_req;
  logic              ld_write;
  logic              ld_lock;
  logic [ADSize-1:0] ld_addr;
  logic [DASize-1:0] ld_wdata;
  logic              ld_gnt;
  logic              ld_rvalid;
  logic [DASize-1:0] ld_rdata;

  logic              IM_enable;
  logic              IM_write;
  logic [ADSize-1:0] IM_address;
  logic [DASize-1:0] IM_in;
  logic [DASize-1:0] IM_out;

  modport slave (
    input  fetch_req, fetch_addr,
    input  ld_req, ld_write, ld_lock, ld_addr, ld_wdata,
    input  IM_out,
    output fetch_gnt, fetch_rvalid, fetch_rdata,
    output ld_gnt, ld_rvalid, ld_rdata,
    output IM_enable, IM_write, IM_address, IM_in
  );

  modport master (
    output fetch_req, fetch_addr,
    output ld_req, ld_write, ld_lock, ld_addr, ld_wdata,
    output IM_out,
    input  fetch_gnt, fetch_rvalid, fetch_rdata,
    input  ld_gnt, ld_rvalid, ld_rdata,
    input  IM_enable, IM_write, IM_address, IM_in
  );
endinterface

// File: rtl/im_port_arbiter.sv
// Round-robin arbiter for the single instruction-memory port, with loader burst lock,
// bounded fetch starvation and 1-cycle registered read return per requester.
`timescale 1ns/1ps
module im_port_arbiter #(
  parameter int unsigned ADSize   = 16,
  parameter int unsigned DASize   = 32,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic            clk,
  input  logic            rst,
  im_port_arbiter_if.slave bus
);

  typedef enum logic {OwnFetch, OwnLoader} owner_e;

  localparam logic [7:0] MaxLock = 8'(MAX_LOCK);

  owner_e            last_owner_q;
  logic [7:0]        lock_cnt_q;
  logic              pend_fetch_rd_q;
  logic              pend_ld_rd_q;
  logic [DASize-1:0] fetch_rdata_q;
  logic [DASize-1:0] ld_rdata_q;

  logic fetch_gnt;
  logic ld_gnt;
  logic both_req;
  logic keep_loader;

  assign both_req    = bus.fetch_req & bus.ld_req;
  assign keep_loader = (last_owner_q == OwnLoader) & bus.ld_lock & (lock_cnt_q < MaxLock);

  always_comb begin
    fetch_gnt = 1'b0;
    ld_gnt    = 1'b0;
    if (!rst) begin
      if (both_req) begin
        if (keep_loader || last_owner_q == OwnFetch) begin
          ld_gnt = 1'b1;
        end else begin
          fetch_gnt = 1'b1;
        end
      end else if (bus.fetch_req) begin
        fetch_gnt = 1'b1;
      end else if (bus.ld_req) begin
        ld_gnt = 1'b1;
      end
    end
  end

  // Only the granted requester's fields reach the memory; idle drives zeros.
  always_comb begin
    bus.IM_address = '0;
    bus.IM_in      = '0;
    if (fetch_gnt) begin
      bus.IM_address = bus.fetch_addr;
    end else if (ld_gnt) begin
      bus.IM_address = bus.ld_addr;
      bus.IM_in      = bus.ld_wdata;
    end
  end

  assign bus.IM_enable = fetch_gnt | ld_gnt;
  assign bus.IM_write  = ld_gnt & bus.ld_write;
  assign bus.fetch_gnt = fetch_gnt;
  assign bus.ld_gnt    = ld_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner_q    <= OwnFetch;
      lock_cnt_q      <= '0;
      pend_fetch_rd_q <= 1'b0;
      pend_ld_rd_q    <= 1'b0;
      fetch_rdata_q   <= '0;
      ld_rdata_q      <= '0;
    end else begin
      if (fetch_gnt) begin
        last_owner_q <= OwnFetch;
      end else if (ld_gnt) begin
        last_owner_q <= OwnLoader;
      end

      // Counts loader grants that made fetch wait; saturates so fetch wins at the limit.
      if (fetch_gnt || !bus.ld_lock) begin
        lock_cnt_q <= '0;
      end else if (ld_gnt && bus.fetch_req && lock_cnt_q != MaxLock) begin
        lock_cnt_q <= lock_cnt_q + 8'd1;
      end

      pend_fetch_rd_q <= fetch_gnt;
      pend_ld_rd_q    <= ld_gnt & ~bus.ld_write;
      if (fetch_gnt) begin
        fetch_rdata_q <= bus.IM_out;
      end
      if (ld_gnt && !bus.ld_write) begin
        ld_rdata_q <= bus.IM_out;
      end
    end
  end

  // A read pending when reset arrives is dropped, so rvalid is masked during reset.
  assign bus.fetch_rvalid = pend_fetch_rd_q & ~rst;
  assign bus.ld_rvalid    = pend_ld_rd_q & ~rst;
  assign bus.fetch_rdata  = fetch_rdata_q;
  assign bus.ld_rdata     = ld_rdata_q;

endmodule
